// File: rtl/hicore_rob_pkg.sv
// Shared widths and entry layout for the HiCore reorder-buffer controller.
package hicore_rob_pkg;

    localparam int unsigned ROB_DEPTH = 8;
    localparam int unsigned PTR_W     = 3;
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned RFIDX_W   = 5;
    localparam int unsigned CSRIDX_W  = 12;
    localparam int unsigned PC_W      = 32;

    // One in-flight instruction as tracked by the ROB
    typedef struct packed {
        logic                valid;
        logic                done;
        logic                excp;
        logic                rd_need;
        logic [RFIDX_W-1:0]  rd_idx;
        logic                csr_need;
        logic [CSRIDX_W-1:0] csr_idx;
        logic [PC_W-1:0]     next_pc;
        logic                fence_i;
        logic                mret;
    } rob_entry_t;

endpackage

// File: rtl/hicore_rob_match.sv
// Per-entry hazard comparator: flags a RAW/CSR conflict between one ROB entry
// and the operands decode wants to read.
module hicore_rob_match
    import hicore_rob_pkg::*;
(
    input  logic                valid,
    input  logic                rd_need,
    input  logic [RFIDX_W-1:0]  rd_idx,
    input  logic                csr_need,
    input  logic [CSRIDX_W-1:0] csr_idx,
    input  logic                src_rs1_need,
    input  logic [RFIDX_W-1:0]  src_rs1_idx,
    input  logic                src_rs2_need,
    input  logic [RFIDX_W-1:0]  src_rs2_idx,
    input  logic                src_csr_need,
    input  logic [CSRIDX_W-1:0] src_csr_idx,
    output logic                hit
);

    logic rs1_hit;
    logic rs2_hit;
    logic csr_hit;

    // x0 never creates a dependency; CSR address 0 is a real CSR and does
    always_comb begin
        rs1_hit = src_rs1_need && rd_need && (rd_idx == src_rs1_idx) && (src_rs1_idx != '0);
        rs2_hit = src_rs2_need && rd_need && (rd_idx == src_rs2_idx) && (src_rs2_idx != '0);
        csr_hit = src_csr_need && csr_need && (csr_idx == src_csr_idx);
        hit     = valid && (rs1_hit || rs2_hit || csr_hit);
    end

endmodule

// File: rtl/hicore_rob_ctrl.sv
// In-order reorder-buffer controller: allocation at tail, writeback marking,
// in-order commit from head, dependency check and flush.
module hicore_rob_ctrl
    import hicore_rob_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_en,
    input  logic                alloc_rd_need,
    input  logic [RFIDX_W-1:0]  alloc_rd_idx,
    input  logic                alloc_csr_need,
    input  logic [CSRIDX_W-1:0] alloc_csr_idx,
    input  logic [PC_W-1:0]     alloc_next_pc,
    input  logic                alloc_fence_i,
    input  logic                alloc_mret,
    output logic [PTR_W-1:0]    tail_ptr,
    output logic                full,
    output logic                empty,
    input  logic                rs1_need,
    input  logic [RFIDX_W-1:0]  rs1_idx,
    input  logic                rs2_need,
    input  logic [RFIDX_W-1:0]  rs2_idx,
    input  logic                csr_need,
    input  logic [CSRIDX_W-1:0] csr_idx,
    output logic                depend,
    input  logic                wb_valid,
    input  logic [PTR_W-1:0]    wb_ptr,
    input  logic                wb_excp,
    output logic                cmt_valid,
    input  logic                cmt_ready,
    output logic [PTR_W-1:0]    cmt_ptr,
    output logic                cmt_rd_need,
    output logic [RFIDX_W-1:0]  cmt_rd_idx,
    output logic                cmt_csr_need,
    output logic [CSRIDX_W-1:0] cmt_csr_idx,
    output logic [PC_W-1:0]     cmt_next_pc,
    output logic                cmt_fence_i,
    output logic                cmt_mret,
    output logic                cmt_excp,
    input  logic                flush
);

    rob_entry_t           entries [ROB_DEPTH];
    rob_entry_t           new_entry;
    rob_entry_t           head_entry;
    logic [PTR_W-1:0]     head_ptr;
    logic [CNT_W-1:0]     count;
    logic                 do_alloc;
    logic                 do_pop;
    logic [ROB_DEPTH-1:0] hit_vec;

    // Status and handshakes, all derived from registered state except cmt_ready/alloc_en gating
    always_comb begin
        full       = (count == CNT_W'(ROB_DEPTH));
        empty      = (count == '0);
        head_entry = entries[head_ptr];
        cmt_valid  = head_entry.valid && head_entry.done;
        do_alloc   = alloc_en && !full;
        do_pop     = cmt_valid && cmt_ready;
    end

    // Fresh entry as written at the tail
    always_comb begin
        new_entry          = '0;
        new_entry.valid    = 1'b1;
        new_entry.rd_need  = alloc_rd_need;
        new_entry.rd_idx   = alloc_rd_idx;
        new_entry.csr_need = alloc_csr_need;
        new_entry.csr_idx  = alloc_csr_idx;
        new_entry.next_pc  = alloc_next_pc;
        new_entry.fence_i  = alloc_fence_i;
        new_entry.mret     = alloc_mret;
    end

    // Head entry presented to commit
    always_comb begin
        cmt_ptr      = head_ptr;
        cmt_rd_need  = head_entry.rd_need;
        cmt_rd_idx   = head_entry.rd_idx;
        cmt_csr_need = head_entry.csr_need;
        cmt_csr_idx  = head_entry.csr_idx;
        cmt_next_pc  = head_entry.next_pc;
        cmt_fence_i  = head_entry.fence_i;
        cmt_mret     = head_entry.mret;
        cmt_excp     = head_entry.excp;
    end

    // Entry storage, pointers and occupancy; flush behaves exactly like reset
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                entries[i] <= '0;
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (wb_valid && entries[wb_ptr].valid) begin
                entries[wb_ptr].done <= 1'b1;
                entries[wb_ptr].excp <= wb_excp;
            end
            if (do_pop) begin
                entries[head_ptr].valid <= 1'b0;
                head_ptr                <= head_ptr + PTR_W'(1);
            end
            if (do_alloc) begin
                entries[tail_ptr] <= new_entry;
                tail_ptr          <= tail_ptr + PTR_W'(1);
            end
            case ({do_alloc, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // One hazard comparator per entry, OR-reduced into the decode stall
    for (genvar g = 0; g < int'(ROB_DEPTH); g++) begin : g_match
        hicore_rob_match u_match (
            .valid        (entries[g].valid),
            .rd_need      (entries[g].rd_need),
            .rd_idx       (entries[g].rd_idx),
            .csr_need     (entries[g].csr_need),
            .csr_idx      (entries[g].csr_idx),
            .src_rs1_need (rs1_need),
            .src_rs1_idx  (rs1_idx),
            .src_rs2_need (rs2_need),
            .src_rs2_idx  (rs2_idx),
            .src_csr_need (csr_need),
            .src_csr_idx  (csr_idx),
            .hit          (hit_vec[g])
        );
    end

    // Decode stall
    always_comb begin
        depend = |hit_vec;
    end

endmodule

// File: doc/hicore_rob_ctrl.md
Name: hicore_rob_ctrl

Overview:
In-order reorder-buffer controller for the HiCore decode/issue path.
- Allocates one entry per decoded instruction and hands decode the tail pointer, full and empty.
- Resolves RAW/CSR dependencies against in-flight entries.
- Marks entries done on execution writeback, and presents the head entry to the commit stage in program order.
- Flush from commit discards every in-flight entry.

Parameters:
ROB_DEPTH, 8, number of entries; power of two, at least 2
PTR_W, 3, log2(ROB_DEPTH)
RFIDX_W, 5, register-file index width
CSRIDX_W, 12, CSR address width
PC_W, 32, PC width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
alloc_en  in  1  allocate entry at tail this cycle
alloc_rd_need  in  1  entry writes rd
alloc_rd_idx  in  RFIDX_W  destination register
alloc_csr_need  in  1  entry writes a CSR
alloc_csr_idx  in  CSRIDX_W  destination CSR
alloc_next_pc  in  PC_W  architectural next PC of entry
alloc_fence_i  in  1  entry is fence.i
alloc_mret  in  1  entry is mret
tail_ptr  out  PTR_W  index the next allocation will receive
full  out  1  all entries occupied
empty  out  1  no entries occupied
rs1_need, rs2_need  in  1 each  decode reads rs1 / rs2
rs1_idx, rs2_idx  in  RFIDX_W each  source registers
csr_need  in  1  decode reads a CSR
csr_idx  in  CSRIDX_W  source CSR
depend  out  1  decode must stall
wb_valid  in  1  execution unit completed an entry
wb_ptr  in  PTR_W  completed entry index
wb_excp  in  1  completed entry raised an exception
cmt_valid  out  1  head entry is done and ready to retire
cmt_ready  in  1  commit accepts head
cmt_ptr  out  PTR_W  head index
cmt_rd_need, cmt_rd_idx, cmt_csr_need, cmt_csr_idx, cmt_next_pc, cmt_fence_i, cmt_mret, cmt_excp  out  as alloc_*  head entry fields
flush  in  1  discard all entries

Behaviour:
- Storage and pointers:
  - Per entry: valid, done, excp, plus all alloc_* fields.
  - head_ptr and tail_ptr are PTR_W bits and wrap modulo ROB_DEPTH.
  - count is PTR_W+1 bits.
- Reset (rst_n=0 at a clock edge):
  - All valid/done cleared; head=tail=0; count=0.
  - Outputs become: tail_ptr=0, full=0, empty=1, cmt_valid=0, depend=0.
  - Reset asserted mid-operation discards all entries.
- Flush: identical effect to reset, one cycle. It has priority over alloc, writeback and pop in the same cycle.
- Allocate: on alloc_en && !full, write entry[tail] with valid=1, done=0, excp=0 and the fields; tail increments.
  - alloc_en while full is ignored with no state change; the bench flags it as an error.
- Writeback: on wb_valid && entry[wb_ptr].valid, set done=1 and excp=wb_excp.
  - Writeback to an invalid entry is ignored.
  - The result is visible on cmt_* the next cycle.
- Commit:
  - cmt_valid = entry[head].valid && entry[head].done, combinational from registers.
  - cmt_* and cmt_ptr reflect entry[head].
  - Pop on cmt_valid && cmt_ready: clear valid, head increments.
- Count update:
  - Alloc and pop in the same cycle: count unchanged, both pointers advance.
  - Alloc only: count+1. Pop only: count-1.
  - full = (count==ROB_DEPTH); empty = (count==0); both registered-derived with no combinational path from alloc_en.
- Dependency check (depend), combinational, for each valid entry e:
  - rs1: rs1_need && e.rd_need && e.rd_idx==rs1_idx && rs1_idx!=0.
  - rs2: the same test with rs2_need/rs2_idx.
  - CSR: csr_need && e.csr_need && e.csr_idx==csr_idx.
  - depend is the OR over all valid entries.
  - Done-but-not-committed entries still cause dependency; there is no bypass.
  - An entry allocated this cycle is not visible until the next cycle.
  - An entry popped this cycle still counts this cycle.
- Latency:
  - Allocate to visible in depend, full and tail_ptr: 1 cycle.
  - Writeback to cmt_valid: 1 cycle.
  - Pop to entry freed: 1 cycle.

Decomposition:
- Shared package hicore_rob_pkg:
  - Width constants: ROB_DEPTH, PTR_W, RFIDX_W, CSRIDX_W, PC_W.
  - Entry struct typedef: valid, done, excp, rd_need, rd_idx, csr_need, csr_idx, next_pc, fence_i, mret.
- One sub-module, hicore_rob_match:
  - Per-entry comparator producing a hit bit from the entry fields and the decode source fields.
  - ROB_DEPTH instances are OR-reduced to form depend.

Test Plan:
1. Reset then idle -> empty=1, full=0, tail_ptr=0, cmt_valid=0, depend=0.
2. Allocate 8 entries (rd_idx 1..8), no writeback -> full=1 after 8th edge, tail_ptr=0 (wrapped); 9th alloc_en ignored, count stays 8.
3. Entry 0 rd_idx=5 allocated; next cycle rs1_need=1, rs1_idx=5 -> depend=1. rs1_idx=0 with rd_idx=0 entry -> depend=0. rs2_need=0, rs2_idx=5 -> depend=0.
4. Alloc ptr0..2; writeback ptr2 then ptr0 -> cmt_valid=1 for ptr0 only; pop ptr0; head=1 not done so cmt_valid=0; writeback ptr1 -> ptr1 then ptr2 retire in order; cmt_excp carries wb_excp.
5. Full ROB with head done; alloc_en and pop in the same cycle -> pop taken, alloc rejected (full sampled), count 7. With count 7, simultaneous alloc+pop -> count stays 7, head and tail both advance and wrap.
6. Four entries in flight, flush asserted together with alloc_en and wb_valid -> next cycle empty=1, tail_ptr=0, cmt_valid=0, depend=0; new alloc goes to ptr0.
